// File: rtl/sprite_ctrl_pkg.sv
// Shared constants, key-event payload and FSM state type for the sprite position controller.
package sprite_ctrl_pkg;

  // PS/2 set-2 scancodes recognised by the controller
  localparam logic [7:0] SC_W         = 8'h1D;
  localparam logic [7:0] SC_A         = 8'h1C;
  localparam logic [7:0] SC_S         = 8'h1B;
  localparam logic [7:0] SC_D         = 8'h23;
  localparam logic [7:0] SC_EXT_UP    = 8'h75;
  localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
  localparam logic [7:0] SC_TAB       = 8'h0D;
  localparam logic [7:0] SC_SPACE     = 8'h29;

  // ps2_key field positions
  localparam int unsigned KEY_W        = 11;
  localparam int unsigned KEY_TOGGLE   = 10;
  localparam int unsigned KEY_PRESSED  = 9;
  localparam int unsigned KEY_EXTENDED = 8;
  localparam int unsigned KEY_CODE_MSB = 7;

  // Bit positions inside a 4-bit direction vector
  localparam int unsigned NUM_DIRS = 4;
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef struct packed {
    logic [NUM_DIRS-1:0] dir_press;
    logic [NUM_DIRS-1:0] dir_release;
    logic                tab_press;
    logic                space_press;
  } key_evt_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE    = 2'd1,
    ST_PUBLISH = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/sprite_position_ctrl_if.sv
// Key/vblank inputs and published sprite state towards pixel_selector.
interface sprite_position_ctrl_if #(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned X_WIDTH     = 11,
  parameter int unsigned Y_WIDTH     = 10,
  parameter int unsigned NUM_FRAMES  = 16
);
  import sprite_ctrl_pkg::*;

  localparam int unsigned FW = $clog2(NUM_FRAMES);
  localparam int unsigned AW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  logic [KEY_W-1:0]             ps2_key;
  logic                         vblank;
  logic [NUM_SPRITES*X_WIDTH-1:0] sprite_x;
  logic [NUM_SPRITES*Y_WIDTH-1:0] sprite_y;
  logic [NUM_SPRITES*FW-1:0]    sprite_frame;
  logic [AW-1:0]                active_sprite;
  logic                         frame_update;

  modport master (
    output ps2_key, vblank,
    input  sprite_x, sprite_y, sprite_frame, active_sprite, frame_update
  );

  modport slave (
    input  ps2_key, vblank,
    output sprite_x, sprite_y, sprite_frame, active_sprite, frame_update
  );

endinterface

// File: rtl/ps2_key_event.sv
// Detects ps2_key toggle events and decodes them into one-cycle key pulses.
module ps2_key_event
  import sprite_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [KEY_W-1:0] ps2_key,
  output key_evt_t         evt
);

  logic                toggle_q;
  logic                event_c;
  logic                pressed_c;
  logic                ext_c;
  logic [7:0]          code_c;
  logic [NUM_DIRS-1:0] dir_hit_c;
  logic                tab_hit_c;
  logic                space_hit_c;

  // Field split and scancode match; arrows accept both WASD and extended codes
  always_comb begin
    code_c    = ps2_key[KEY_CODE_MSB:0];
    ext_c     = ps2_key[KEY_EXTENDED];
    pressed_c = ps2_key[KEY_PRESSED];
    event_c   = ps2_key[KEY_TOGGLE] != toggle_q;
    dir_hit_c = '0;
    dir_hit_c[DIR_UP]    = ext_c ? (code_c == SC_EXT_UP)    : (code_c == SC_W);
    dir_hit_c[DIR_LEFT]  = ext_c ? (code_c == SC_EXT_LEFT)  : (code_c == SC_A);
    dir_hit_c[DIR_DOWN]  = ext_c ? (code_c == SC_EXT_DOWN)  : (code_c == SC_S);
    dir_hit_c[DIR_RIGHT] = ext_c ? (code_c == SC_EXT_RIGHT) : (code_c == SC_D);
    tab_hit_c   = !ext_c && (code_c == SC_TAB);
    space_hit_c = !ext_c && (code_c == SC_SPACE);
  end

  // Toggle copy and registered event pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q <= 1'b0;
      evt      <= '0;
    end else begin
      toggle_q        <= ps2_key[KEY_TOGGLE];
      evt.dir_press   <= (event_c && pressed_c)  ? dir_hit_c : '0;
      evt.dir_release <= (event_c && !pressed_c) ? dir_hit_c : '0;
      evt.tab_press   <= event_c && pressed_c && tab_hit_c;
      evt.space_press <= event_c && pressed_c && space_hit_c;
    end
  end

endmodule

// File: rtl/sprite_position_ctrl.sv
// Keyboard-driven sprite position/frame controller with per-vblank clamped movement and double-buffered outputs.
module sprite_position_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 4,
  parameter int unsigned X_WIDTH      = 11,
  parameter int unsigned Y_WIDTH      = 10,
  parameter int unsigned X_LIMIT      = 1280,
  parameter int unsigned Y_LIMIT      = 500,
  parameter int unsigned SPRITE_W     = 32,
  parameter int unsigned SPRITE_H     = 32,
  parameter int unsigned STEP         = 1,
  parameter int unsigned NUM_FRAMES   = 16,
  parameter int unsigned REPEAT_DELAY = 20,
  parameter int unsigned REPEAT_RATE  = 4,
  parameter int unsigned INIT_X       = 100,
  parameter int unsigned INIT_Y       = 100
) (
  input logic                   clk,
  input logic                   reset_n,
  sprite_position_ctrl_if.slave bus
);

  localparam int unsigned FW    = $clog2(NUM_FRAMES);
  localparam int unsigned AW    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int unsigned XE    = X_WIDTH + 1;
  localparam int unsigned YE    = Y_WIDTH + 1;
  localparam int unsigned X_MAX = X_LIMIT - SPRITE_W;
  localparam int unsigned Y_MAX = Y_LIMIT - SPRITE_H;
  localparam int unsigned HW    = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam int unsigned RW    = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;

  key_evt_t            evt;
  ctrl_state_t         state, state_nxt;
  logic                move_c, publish_c;
  logic                vblank_q, vblank_p;
  logic [X_WIDTH-1:0]  x_w     [NUM_SPRITES];
  logic [Y_WIDTH-1:0]  y_w     [NUM_SPRITES];
  logic [FW-1:0]       frame_w [NUM_SPRITES];
  logic [AW-1:0]       active_w;
  logic [NUM_DIRS-1:0] held, pend, rise_c, step_dirs_c;
  logic [HW-1:0]       hold_cnt;
  logic [RW-1:0]       rate_cnt;
  logic                step_now_c;
  logic [XE-1:0]       x_sum_c, x_dif_c;
  logic [YE-1:0]       y_sum_c, y_dif_c;
  logic [X_WIDTH-1:0]  x_new_c;
  logic [Y_WIDTH-1:0]  y_new_c;

  ps2_key_event u_key (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_key (bus.ps2_key),
    .evt     (evt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: one MOVE and one PUBLISH cycle per vblank rising edge
  always_comb begin
    state_nxt = state;
    move_c    = 1'b0;
    publish_c = 1'b0;
    case (state)
      ST_IDLE:    if (vblank_q && !vblank_p) state_nxt = ST_MOVE;
      ST_MOVE:    begin move_c = 1'b1; state_nxt = ST_PUBLISH; end
      ST_PUBLISH: begin publish_c = 1'b1; state_nxt = ST_IDLE; end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Step decision: pending first step (which also covers tapped-and-released keys) or auto-repeat
  always_comb begin
    rise_c      = evt.dir_press & ~held;
    step_dirs_c = held;
    step_now_c  = 1'b0;
    if (|pend) begin
      step_dirs_c = held | pend;
      step_now_c  = 1'b1;
    end else if ((hold_cnt >= HW'(REPEAT_DELAY)) && (rate_cnt == '0)) begin
      step_now_c = |held;
    end
  end

  // Clamped next coordinates of the active sprite; opposing directions cancel
  always_comb begin
    x_sum_c = {1'b0, x_w[active_w]} + XE'(STEP);
    x_dif_c = {1'b0, x_w[active_w]} - XE'(STEP);
    y_sum_c = {1'b0, y_w[active_w]} + YE'(STEP);
    y_dif_c = {1'b0, y_w[active_w]} - YE'(STEP);
    x_new_c = x_w[active_w];
    y_new_c = y_w[active_w];
    if (step_dirs_c[DIR_LEFT] && !step_dirs_c[DIR_RIGHT])
      x_new_c = x_dif_c[XE-1] ? '0 : x_dif_c[X_WIDTH-1:0];
    else if (step_dirs_c[DIR_RIGHT] && !step_dirs_c[DIR_LEFT])
      x_new_c = (x_sum_c > XE'(X_MAX)) ? X_WIDTH'(X_MAX) : x_sum_c[X_WIDTH-1:0];
    if (step_dirs_c[DIR_UP] && !step_dirs_c[DIR_DOWN])
      y_new_c = y_dif_c[YE-1] ? '0 : y_dif_c[Y_WIDTH-1:0];
    else if (step_dirs_c[DIR_DOWN] && !step_dirs_c[DIR_UP])
      y_new_c = (y_sum_c > YE'(Y_MAX)) ? Y_WIDTH'(Y_MAX) : y_sum_c[Y_WIDTH-1:0];
  end

  // Working registers, held-key state and repeat counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vblank_q <= 1'b0;
      vblank_p <= 1'b0;
      active_w <= '0;
      held     <= '0;
      pend     <= '0;
      hold_cnt <= '0;
      rate_cnt <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_w[i]     <= X_WIDTH'(INIT_X + i * SPRITE_W);
        y_w[i]     <= Y_WIDTH'(INIT_Y);
        frame_w[i] <= '0;
      end
    end else begin
      vblank_q <= bus.vblank;
      vblank_p <= vblank_q;
      if (move_c && step_now_c) begin
        x_w[active_w] <= x_new_c;
        y_w[active_w] <= y_new_c;
      end
      if (evt.space_press) frame_w[active_w] <= frame_w[active_w] + FW'(1);
      if (evt.tab_press)
        active_w <= (active_w == AW'(NUM_SPRITES - 1)) ? '0 : active_w + AW'(1);
      held <= (held & ~evt.dir_release) | evt.dir_press;
      pend <= (move_c ? '0 : pend) | rise_c;
      if (evt.tab_press || (|rise_c)) begin
        hold_cnt <= '0;
        rate_cnt <= '0;
      end else if (move_c) begin
        if (held == '0) begin
          hold_cnt <= '0;
          rate_cnt <= '0;
        end else if (hold_cnt < HW'(REPEAT_DELAY)) begin
          hold_cnt <= hold_cnt + HW'(1);
        end else begin
          rate_cnt <= (rate_cnt == '0) ? RW'(REPEAT_RATE - 1) : rate_cnt - RW'(1);
        end
      end
    end
  end

  // Shadow copy of the working registers, updated only in PUBLISH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.active_sprite <= '0;
      bus.frame_update  <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        bus.sprite_x[i*X_WIDTH +: X_WIDTH] <= X_WIDTH'(INIT_X + i * SPRITE_W);
        bus.sprite_y[i*Y_WIDTH +: Y_WIDTH] <= Y_WIDTH'(INIT_Y);
        bus.sprite_frame[i*FW +: FW]       <= '0;
      end
    end else begin
      bus.frame_update <= publish_c;
      if (publish_c) begin
        bus.active_sprite <= active_w;
        for (int i = 0; i < NUM_SPRITES; i++) begin
          bus.sprite_x[i*X_WIDTH +: X_WIDTH] <= x_w[i];
          bus.sprite_y[i*Y_WIDTH +: Y_WIDTH] <= y_w[i];
          bus.sprite_frame[i*FW +: FW]       <= frame_w[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_position_ctrl.sv
// Scoreboard bench for sprite_position_ctrl: directed key/vblank stimulus, monitor checks every frame_update.
module tb_sprite_position_ctrl;
  import sprite_ctrl_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned NF = 16;
  localparam int unsigned FW = 4;
  localparam int unsigned AW = 2;

  typedef struct packed {
    logic [NS*XW-1:0] x;
    logic [NS*YW-1:0] y;
    logic [NS*FW-1:0] f;
    logic [AW-1:0]    a;
  } snap_t;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  logic  tog = 1'b0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    exp_x[NS];
  int    exp_y[NS];
  int    exp_f[NS];
  int    exp_a;
  snap_t exp_q[$];
  snap_t last_pub;
  int    tab_seq[5] = '{1, 2, 3, 0, 1};

  always #5 clk = ~clk;

  sprite_position_ctrl_if #(.NUM_SPRITES(NS), .X_WIDTH(XW), .Y_WIDTH(YW), .NUM_FRAMES(NF)) bus ();

  sprite_position_ctrl #(.NUM_SPRITES(NS), .X_WIDTH(XW), .Y_WIDTH(YW), .NUM_FRAMES(NF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic snap_t pack_exp();
    snap_t s;
    s = '0;
    for (int i = 0; i < NS; i++) begin
      s.x[i*XW +: XW] = XW'(exp_x[i]);
      s.y[i*YW +: YW] = YW'(exp_y[i]);
      s.f[i*FW +: FW] = FW'(exp_f[i]);
    end
    s.a = AW'(exp_a);
    return s;
  endfunction

  task automatic reset_exp();
    exp_x = '{100, 132, 164, 196};
    exp_y = '{100, 100, 100, 100};
    exp_f = '{0, 0, 0, 0};
    exp_a = 0;
  endtask

  // Monitor: every published update is compared against the oldest expected snapshot
  always @(negedge clk) begin : monitor
    snap_t e;
    if (bus.frame_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_update: frame_update with empty scoreboard at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("pub_x", 64'(bus.sprite_x), 64'(e.x));
        check("pub_y", 64'(bus.sprite_y), 64'(e.y));
        check("pub_frame", 64'(bus.sprite_frame), 64'(e.f));
        check("pub_active", 64'(bus.active_sprite), 64'(e.a));
      end
    end
  end

  task automatic key(input logic ext, input logic [7:0] code, input logic pressed);
    @(negedge clk);
    tog = ~tog;
    bus.ps2_key = {tog, pressed, ext, code};
    repeat (2) @(negedge clk);
  endtask

  task automatic tap(input logic ext, input logic [7:0] code);
    key(ext, code, 1'b1);
    key(ext, code, 1'b0);
  endtask

  // One-cycle vblank pulse; returns negedges until frame_update is seen (0 = never)
  task automatic run_frame(output int lat);
    @(negedge clk);
    bus.vblank = 1'b1;
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.vblank = 1'b0;
      if (bus.frame_update === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_frame();
    int lat;
    last_pub = pack_exp();
    exp_q.push_back(last_pub);
    run_frame(lat);
    check("update_latency", 64'(lat), 64'd4);
    @(negedge clk);
    check("update_pulse_width", 64'(bus.frame_update), 64'd0);
  endtask

  task automatic check_outputs(input string name, input snap_t s);
    check({name, "_x"}, 64'(bus.sprite_x), 64'(s.x));
    check({name, "_y"}, 64'(bus.sprite_y), 64'(s.y));
    check({name, "_frame"}, 64'(bus.sprite_frame), 64'(s.f));
    check({name, "_active"}, 64'(bus.active_sprite), 64'(s.a));
    check({name, "_update"}, 64'(bus.frame_update), 64'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lat;
    bus.ps2_key = '0;
    bus.vblank  = 1'b0;
    reset_exp();
    last_pub = pack_exp();
    repeat (3) @(negedge clk);
    check_outputs("reset", last_pub);
    reset_n = 1'b1;
    @(negedge clk);

    // Idle frame publishes unchanged reset values
    do_frame();

    // Hold D: first step immediately, repeats at frames 21, 25, 29
    key(1'b0, SC_D, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      exp_x[0] = (k < 21) ? 101 : (k < 25) ? 102 : (k < 29) ? 103 : 104;
      do_frame();
    end
    key(1'b0, SC_D, 1'b0);

    // Tab x5: active index only visible after the next update
    for (int k = 0; k < 5; k++) begin
      tap(1'b0, SC_TAB);
      check("active_before_update", 64'(bus.active_sprite), 64'(last_pub.a));
      exp_a = tab_seq[k];
      do_frame();
    end

    // Space x17 on sprite 1 wraps frame index to 1
    repeat (17) tap(1'b0, SC_SPACE);
    check("frame_before_update", 64'(bus.sprite_frame), 64'(last_pub.f));
    exp_f[1] = 1;
    do_frame();

    // Back to sprite 0
    repeat (3) tap(1'b0, SC_TAB);
    exp_a = 0;
    do_frame();

    // Diagonal taps drive sprite 0 to y=0, then right taps to x=1247
    for (int k = 0; k < 100; k++) begin
      key(1'b0, SC_D, 1'b1);
      key(1'b0, SC_W, 1'b1);
      key(1'b0, SC_D, 1'b0);
      key(1'b0, SC_W, 1'b0);
      exp_x[0] = exp_x[0] + 1;
      exp_y[0] = exp_y[0] - 1;
      do_frame();
    end
    for (int k = 0; k < 1043; k++) begin
      tap(1'b0, SC_D);
      exp_x[0] = exp_x[0] + 1;
      do_frame();
    end
    check("x_reached_1247", 64'(bus.sprite_x[XW-1:0]), 64'd1247);

    // Hold extended Right and W: x clamps at 1248, y stays 0 through repeats
    key(1'b1, SC_EXT_RIGHT, 1'b1);
    key(1'b0, SC_W, 1'b1);
    exp_x[0] = 1248;
    exp_y[0] = 0;
    repeat (26) do_frame();
    key(1'b1, SC_EXT_RIGHT, 1'b0);
    key(1'b0, SC_W, 1'b0);

    // A+D cancel on x while S moves y down
    key(1'b0, SC_A, 1'b1);
    key(1'b0, SC_D, 1'b1);
    key(1'b0, SC_S, 1'b1);
    exp_y[0] = 1;
    repeat (3) do_frame();
    key(1'b0, SC_A, 1'b0);
    key(1'b0, SC_D, 1'b0);
    key(1'b0, SC_S, 1'b0);
    tap(1'b0, SC_S);
    exp_y[0] = 2;
    do_frame();
    tap(1'b0, SC_S);
    exp_y[0] = 3;
    do_frame();

    // W pressed and released inside one frame: exactly one step up
    tap(1'b0, SC_W);
    exp_y[0] = 2;
    do_frame();

    // Reset while frame_update is high
    key(1'b0, SC_A, 1'b1);
    exp_x[0] = 1247;
    last_pub = pack_exp();
    exp_q.push_back(last_pub);
    run_frame(lat);
    check("update_latency_pre_reset", 64'(lat), 64'd4);
    #2;
    reset_n = 1'b0;
    #1;
    tog = 1'b0;
    bus.ps2_key = '0;
    reset_exp();
    last_pub = pack_exp();
    check_outputs("async_reset", last_pub);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // First step after reset lands on the first vblank
    key(1'b0, SC_D, 1'b1);
    exp_x[0] = 101;
    do_frame();
    key(1'b0, SC_D, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_position_ctrl.md
# sprite_position_ctrl

Keyboard-driven position and animation-frame controller for up to `NUM_SPRITES` sprites. It is the parametrised successor to the single hard-coded sprite cursor in the emu top level. It decodes `ps2_key` events into held-direction state and applies clamped movement once per video frame, with press-and-hold auto-repeat. It publishes tear-free, double-buffered sprite coordinates, frame indices and the active-sprite index to `pixel_selector`.

## Interface
- `NUM_SPRITES`, 4: number of controlled sprites (1..16).
- `X_WIDTH`, 11: x coordinate width.
- `Y_WIDTH`, 10: y coordinate width.
- `X_LIMIT`, 1280: playfield width in pixels.
- `Y_LIMIT`, 500: playfield height in pixels.
- `SPRITE_W`, 32: sprite width in pixels.
- `SPRITE_H`, 32: sprite height in pixels.
- `STEP`, 1: pixels moved per step (1..SPRITE_W).
- `NUM_FRAMES`, 16: animation frames per sprite (power of two).
- `REPEAT_DELAY`, 20: frames a key is held before auto-repeat starts.
- `REPEAT_RATE`, 4: frames between auto-repeat steps (≥1).
- `INIT_X`, 100: reset x of sprite 0.
- `INIT_Y`, 100: reset y of all sprites.
- `clk`  in  1  video clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_key`  in  11  hps_io key bus: [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
- `vblank`  in  1  vertical blank from vga_driver.
- `sprite_x`  out  NUM_SPRITES*X_WIDTH  published x positions, sprite i at [i*X_WIDTH +: X_WIDTH].
- `sprite_y`  out  NUM_SPRITES*Y_WIDTH  published y positions, packed the same way.
- `sprite_frame`  out  NUM_SPRITES*$clog2(NUM_FRAMES)  published animation frame indices.
- `active_sprite`  out  $clog2(NUM_SPRITES) (min 1)  published selected sprite.
- `frame_update`  out  1  one-cycle pulse when the published outputs change.

## Operation
- **Key events.** An event fires whenever `ps2_key[10]` differs from its registered copy. `[9]=1` means press, `[9]=0` means release.
- **Direction keys.**
  - Up: W (0x1D, `[8]=0`) or extended 0x75.
  - Left: A (0x1C) or extended 0x6B.
  - Down: S (0x1B) or extended 0x72.
  - Right: D (0x23) or extended 0x74.
  - Press sets the held bit for that direction; release clears it. All four held bits are independent.
- **Tab (0x0D, press).** `active_w` increments, wrapping from NUM_SPRITES-1 to 0. The repeat counter is cleared. Held bits are kept and apply to the new sprite.
- **Space (0x29, press).** The frame of the active sprite increments modulo NUM_FRAMES.
- All other scancodes are ignored, as are releases of Tab and Space.
- **Working registers** (x, y, frame per sprite, `active_w`) update on events. Outputs are shadow copies of these registers.
- **FSM** states are IDLE, MOVE and PUBLISH.
  - IDLE → MOVE on the vblank rising edge (registered `vblank`=1, previous=0).
  - MOVE → PUBLISH unconditionally. In MOVE the active sprite is stepped if the step condition holds, and the repeat counter is advanced.
  - PUBLISH → IDLE unconditionally. PUBLISH copies the working registers to the outputs and pulses `frame_update`.
- **Step condition.** A direction becomes newly held when its held bit goes from 0 to 1. When that happens, the hold counter clears and a pending-first-step flag sets. In MOVE:
  - Step if the flag is set, then clear the flag.
  - Otherwise, if the hold counter ≥ REPEAT_DELAY and the rate counter = 0, step.
  - The rate counter counts REPEAT_RATE-1 down to 0, then reloads.
  - The hold counter saturates at REPEAT_DELAY.
  - With no held bits, both counters clear.
- **Axis rules.**
  - If both Up and Down are held, y does not change; the same applies to Left and Right for x.
  - Diagonal movement steps both axes in the same MOVE.
- **Clamping.**
  - x is limited to [0, X_LIMIT-SPRITE_W] and y to [0, Y_LIMIT-SPRITE_H].
  - A step that would cross a bound sets the coordinate to the bound.
  - All arithmetic uses one extra bit of width, so there is no wrap-around.
- **Reset values.**
  - Sprite i: x = INIT_X + i*SPRITE_W, y = INIT_Y, frame 0.
  - `active_sprite` = 0, `frame_update` = 0, FSM in IDLE.
  - Held bits, flags and counters = 0.
  - Outputs hold the same reset values as the working registers.
  - Parameters must satisfy INIT_X + (NUM_SPRITES-1)*SPRITE_W ≤ X_LIMIT-SPRITE_W.

## Timing
- Let edge E be the first clk edge that samples `vblank`=1.
  - The FSM enters MOVE at E+1 and PUBLISH at E+2.
  - Outputs change, and `frame_update` is high, for the cycle following edge E+3.
- Outputs are stable between `frame_update` pulses; there are never mid-frame changes.
- Key events are processed in every state, including MOVE and PUBLISH.
- If Space or Tab arrives in the PUBLISH cycle, the pre-event value is copied. The new value appears at the next vblank.
- A direction press in the MOVE cycle takes effect at the next vblank.
- A press and release that both land between two vblanks still yield exactly one step, because the pending flag persists across the release.
- Asserting `reset_n` low mid-frame or mid-FSM returns all state to reset values immediately (asynchronously).

## Structure
- Package `sprite_ctrl_pkg` holds:
  - scancode localparams (W/A/S/D, the four extended arrows, Tab, Space);
  - `ps2_key` field index constants;
  - the FSM state enum `ctrl_state_t`.
- Sub-module `ps2_key_event` handles toggle detection and decoding into one-cycle press/release pulses per supported key.

## Test plan
- Reset with defaults → outputs x = {100,132,164,196}, y = 100, frames 0, `active_sprite` 0, no `frame_update`.
- Press D, then hold through 30 vblanks → sprite 0 x:
  - 101 after the first `frame_update`;
  - no further change through frame 20;
  - +1 at frames 21, 25 and 29, so x = 104 after 30 frames.
- Tab ×5 with NUM_SPRITES=4 → `active_sprite` 1, 2, 3, 0, 1, each visible only after the next `frame_update`. Space ×17 on sprite 1 → its frame = 1 (wrap at 16).
- Sprite 0 at x=1247, hold Right (extended 0x74) → x clamps at 1248 and stays there. At y=0, hold W → y stays 0.
- Hold A and D together plus S → x unchanged, y increments. Press and release W within one frame → exactly one y-1 step.
- Assert `reset_n` low during PUBLISH → `frame_update` drops asynchronously and outputs return to reset values. After release, the first step occurs at the first vblank.
